// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM controller that fetches 16-bit instructions from a synchronous ROM and drives the datapath controls.
// Latency: NOOP/STORE/illegal take 3 cycles FETCH-to-FETCH; LOAD/ADD/SUB/JPZ take 4; HALT holds until reset.
// Backpressure: none; the ROM and datapath are assumed to keep pace every cycle, and zero_flag is sampled at the end of ALU_WB.
//
// Ports:
//   Clock, rst                 - system clock; asynchronous active-high reset
//   IM_Addr / IM_Data          - instruction ROM address (the PC) and its registered data
//   D_Addr, D_Wr               - data-memory address and write enable
//   RF_s, RF_W_Addr, RF_W_en   - write-back select (0 ALU, 1 memory), write address, write enable
//   RF_Ra_Addr, RF_Rb_Addr     - register-file read addresses
//   ALU_s0                     - ALU operation select
//   zero_flag                  - datapath zero flag, feeds the internal Z register
//   state, halted              - debug state code and HALT indicator
module control_unit #(
  parameter logic [2:0] ALU_ADD = 3'b001,
  parameter logic [2:0] ALU_SUB = 3'b010
) (
  input  logic        Clock,
  input  logic        rst,
  output logic [7:0]  IM_Addr,
  input  logic [15:0] IM_Data,
  output logic [7:0]  D_Addr,
  output logic        D_Wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_Addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_Addr,
  output logic [3:0]  RF_Rb_Addr,
  output logic [2:0]  ALU_s0,
  input  logic        zero_flag,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ALU_EX = 4'd7,
    S_ALU_WB = 4'd8,
    S_JPZ    = 4'd9,
    S_HALT   = 4'd10
  } state_t;

  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;
  localparam logic [3:0] OP_JPZ   = 4'b0110;

  // All datapath controls travel together so they can be registered and cleared as one.
  typedef struct packed {
    logic [7:0] d_addr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] rf_w_addr;
    logic       rf_w_en;
    logic [3:0] rf_ra;
    logic [3:0] rf_rb;
    logic [2:0] alu_s;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        z_q, z_d;
  logic        halted_q, halted_d;
  ctrl_t       ctrl_q, ctrl_d;

  logic [3:0] op_f, a_f, b_f, c_f;
  logic [7:0] m_f;
  logic [2:0] alu_sel;

  assign op_f = ir_q[15:12];
  assign a_f  = ir_q[11:8];
  assign b_f  = ir_q[7:4];
  assign c_f  = ir_q[3:0];
  assign m_f  = ir_q[11:4];
  assign alu_sel = (op_f == OP_SUB) ? ALU_SUB : ALU_ADD;

  // Outputs are registered: the control values for a state are computed on the
  // transition into it, so each output is glitch-free for the whole state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    ctrl_d   = '0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = IM_Data;
        pc_d    = pc_q + 8'd1;  // natural 8-bit wrap 255 -> 0
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_f)
          OP_STORE: begin
            state_d       = S_STORE;
            ctrl_d.d_addr = m_f;
            ctrl_d.rf_ra  = c_f;
            ctrl_d.d_wr   = 1'b1;
          end
          OP_LOAD: begin
            state_d       = S_LOAD_A;
            ctrl_d.d_addr = m_f;
          end
          OP_ADD, OP_SUB: begin
            state_d      = S_ALU_EX;
            ctrl_d.rf_ra = a_f;
            ctrl_d.rf_rb = b_f;
            ctrl_d.alu_s = alu_sel;
          end
          OP_HALT: state_d = S_HALT;
          OP_JPZ:  state_d = S_JPZ;
          default: state_d = S_NOOP;  // NOOP and all unassigned opcodes
        endcase
      end
      S_LOAD_A: begin
        state_d          = S_LOAD_B;
        ctrl_d.d_addr    = m_f;
        ctrl_d.rf_s      = 1'b1;
        ctrl_d.rf_w_en   = 1'b1;
        ctrl_d.rf_w_addr = c_f;
      end
      S_ALU_EX: begin
        state_d          = S_ALU_WB;
        ctrl_d.rf_ra     = a_f;
        ctrl_d.rf_rb     = b_f;
        ctrl_d.alu_s     = alu_sel;
        ctrl_d.rf_w_en   = 1'b1;
        ctrl_d.rf_w_addr = c_f;
      end
      S_ALU_WB: begin
        z_d     = zero_flag;
        state_d = S_FETCH;
      end
      S_JPZ: begin
        if (z_q) pc_d = m_f;
        // The trailing NOOP gives the ROM a cycle to present the new address.
        state_d = S_NOOP;
      end
      S_LOAD_B, S_STORE, S_NOOP: state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      state_q  <= S_INIT;
      pc_q     <= 8'h00;
      ir_q     <= 16'h0000;
      z_q      <= 1'b0;
      halted_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      halted_q <= halted_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign IM_Addr    = pc_q;
  assign state      = state_q;
  assign halted     = halted_q;
  assign D_Addr     = ctrl_q.d_addr;
  assign D_Wr       = ctrl_q.d_wr;
  assign RF_s       = ctrl_q.rf_s;
  assign RF_W_Addr  = ctrl_q.rf_w_addr;
  assign RF_W_en    = ctrl_q.rf_w_en;
  assign RF_Ra_Addr = ctrl_q.rf_ra;
  assign RF_Rb_Addr = ctrl_q.rf_rb;
  assign ALU_s0     = ctrl_q.alu_s;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed-vector bench for control_unit with a behavioural synchronous ROM.
// Latency: outputs sampled on the falling edge, half a cycle after each state change.
// Backpressure: none; the bench drives zero_flag directly.
module tb_control_unit;

  logic        Clock;
  logic        rst;
  logic [7:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic [3:0]  RF_W_Addr;
  logic        RF_W_en;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic        zero_flag;
  logic [3:0]  state;
  logic        halted;

  logic [15:0] rom [256];
  logic [25:0] ctl;
  int n_vec = 0;
  int n_err = 0;

  control_unit #(.ALU_ADD(3'b001), .ALU_SUB(3'b010)) dut (
    .Clock(Clock), .rst(rst), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_Addr(RF_W_Addr),
    .RF_W_en(RF_W_en), .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr),
    .ALU_s0(ALU_s0), .zero_flag(zero_flag), .state(state), .halted(halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous ROM: data appears one edge after the address.
  always @(posedge Clock) IM_Data <= rom[IM_Addr];

  assign ctl = {D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0};

  function automatic logic [25:0] mk_ctl(input logic [7:0] d_addr, input logic d_wr,
                                         input logic rf_s, input logic [3:0] w_addr,
                                         input logic w_en, input logic [3:0] ra,
                                         input logic [3:0] rb, input logic [2:0] alu);
    return {d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic release_rst();
    @(negedge Clock);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    zero_flag = 1'b0;
    clear_rom();
    #1 rst = 1'b1;

    // ---- Reset state, then STORE, then mid-instruction reset ----
    rom[0] = 16'h10A3;
    repeat (2) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_ctl", 32'(ctl), 0);
    chk("rst_pc", 32'(IM_Addr), 0);
    chk("rst_halted", 32'(halted), 0);
    release_rst();
    chk("st_init", 32'(state), 0);
    tick(); chk("st_fetch", 32'(state), 1);
    tick(); chk("st_decode", 32'(state), 2);
    chk("st_decode_ctl", 32'(ctl), 0);
    tick(); chk("st_state", 32'(state), 6);
    chk("st_ctl", 32'(ctl), 32'(mk_ctl(8'h0A, 1'b1, 1'b0, 4'h0, 1'b0, 4'h3, 4'h0, 3'b000)));
    #2 rst = 1'b1;
    #1;
    chk("abort_ctl", 32'(ctl), 0);
    chk("abort_state", 32'(state), 0);
    chk("abort_pc", 32'(IM_Addr), 0);

    // ---- HALT right after reset ----
    clear_rom();
    rom[0] = 16'h5000;
    release_rst();
    chk("h_s0", 32'(state), 0);
    tick(); chk("h_s1", 32'(state), 1);
    tick(); chk("h_s2", 32'(state), 2);
    chk("h_halted_early", 32'(halted), 0);
    tick(); chk("h_s10", 32'(state), 10);
    chk("h_halted", 32'(halted), 1);
    chk("h_ctl", 32'(ctl), 0);
    repeat (3) tick();
    chk("h_stay", 32'(state), 10);
    chk("h_halted_stay", 32'(halted), 1);
    chk("h_pc_frozen", 32'(IM_Addr), 1);
    chk("h_ctl_stay", 32'(ctl), 0);

    // ---- LOAD ----
    rst = 1'b1;
    clear_rom();
    rom[0] = 16'h2052;
    release_rst();
    tick(); tick();
    tick(); chk("ld_a_state", 32'(state), 4);
    chk("ld_a_ctl", 32'(ctl), 32'(mk_ctl(8'h05, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000)));
    tick(); chk("ld_b_state", 32'(state), 5);
    chk("ld_b_ctl", 32'(ctl), 32'(mk_ctl(8'h05, 1'b0, 1'b1, 4'h2, 1'b1, 4'h0, 4'h0, 3'b000)));
    tick(); chk("ld_next_fetch", 32'(state), 1);
    chk("ld_next_ctl", 32'(ctl), 0);

    // ---- ADD, SUB, JPZ taken (t=1) and not taken (t=0) ----
    for (int t = 1; t >= 0; t--) begin
      rst = 1'b1;
      zero_flag = 1'b0;
      clear_rom();
      rom[0] = 16'h3124;
      rom[1] = 16'h4124;
      rom[2] = 16'h6400;
      rom[8'h40] = 16'h5000;
      release_rst();
      tick(); tick();
      tick(); chk("add_ex_state", 32'(state), 7);
      chk("add_ex_ctl", 32'(ctl), 32'(mk_ctl(8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h1, 4'h2, 3'b001)));
      tick(); chk("add_wb_state", 32'(state), 8);
      chk("add_wb_ctl", 32'(ctl), 32'(mk_ctl(8'h00, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b001)));
      tick(); chk("sub_fetch_pc", 32'(IM_Addr), 1);
      tick();
      tick(); chk("sub_ex_ctl", 32'(ctl), 32'(mk_ctl(8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h1, 4'h2, 3'b010)));
      tick(); chk("sub_wb_ctl", 32'(ctl), 32'(mk_ctl(8'h00, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b010)));
      zero_flag = (t == 1);
      tick(); zero_flag = 1'b0;
      chk("jpz_fetch_pc", 32'(IM_Addr), 2);
      tick();
      tick(); chk("jpz_state", 32'(state), 9);
      chk("jpz_ctl", 32'(ctl), 0);
      tick(); chk("jpz_pad_state", 32'(state), 3);
      tick(); chk("jpz_next_fetch_state", 32'(state), 1);
      chk("jpz_next_fetch_pc", 32'(IM_Addr), (t == 1) ? 32'h40 : 32'h03);
      tick();
      tick(); chk("jpz_after", 32'(state), (t == 1) ? 32'd10 : 32'd3);
    end

    // ---- Illegal opcode at address 255 and PC wrap ----
    rst = 1'b1;
    clear_rom();
    rom[255] = 16'hF123;
    release_rst();
    n = 0;
    while (!(state == 4'd1 && IM_Addr == 8'hFF) && n < 3000) begin
      tick();
      n++;
    end
    chk("wrap_reached", 32'(n < 3000), 1);
    tick(); chk("wrap_decode_pc", 32'(IM_Addr), 0);
    chk("wrap_decode_state", 32'(state), 2);
    tick(); chk("ill_state", 32'(state), 3);
    chk("ill_ctl", 32'(ctl), 0);
    tick(); chk("wrap_fetch_state", 32'(state), 1);
    chk("wrap_fetch_pc", 32'(IM_Addr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
